handshake_rr_arbiter: RTL and testbench
=======================================

Name: handshake_rr_arbiter

Overview:
Shares one downstream handshake channel (request word on port1, response word on port2) between NREQ upstream requesters, for example one channel per element of a handshake array. Requester selection is round-robin. Only one transaction is outstanding at a time. A response is routed back only to the requester that issued the request. The block sits between source-side array ports and a single drain-side port, and adds valid/ready sequencing and a response timeout.

Parameters:
NREQ, 2, number of upstream requesters (>=2)
WIDTH, 32, data width of port1/port2 words
TIMEOUT, 255, max cycles in WAIT_RSP before forced completion; 0 disables timeout

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
up_valid  input  NREQ  per-requester request valid
up_port1  input  NREQ*WIDTH  request words, requester i at bits [i*WIDTH +: WIDTH]
up_ready  output  NREQ  request accepted (one-hot or zero)
up_rsp_valid  output  NREQ  one-cycle response pulse to granted requester
up_port2  output  WIDTH  response word, broadcast, valid with up_rsp_valid
up_rsp_err  output  1  qualifies up_rsp_valid: 1 = timeout, data is 0
dn_valid  output  1  downstream request valid
dn_ready  input  1  downstream accepts request
dn_port1  output  WIDTH  downstream request word (registered)
dn_rsp_valid  input  1  downstream response valid
dn_port2  input  WIDTH  downstream response word
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=NREQ-1 so requester 0 wins first, all outputs 0, timeout counter 0.
- IDLE:
  - Winner = first i with up_valid[i], scanning from last_grant+1 modulo NREQ.
  - up_ready[winner]=1 combinationally; all other ready bits 0.
  - On acceptance: register grant=winner, dn_port1<=word, dn_valid<=1, go to ISSUE.
  - No valid requester: stay in IDLE, all ready bits 0.
- ISSUE:
  - dn_valid=1 and dn_port1 held stable until dn_ready=1.
  - On dn_ready: dn_valid<=0, counter cleared, go to WAIT_RSP.
  - dn_rsp_valid in ISSUE is ignored; the downstream must not respond before the cycle after dn_ready.
- WAIT_RSP:
  - On dn_rsp_valid: up_port2<=dn_port2, up_rsp_valid[grant]<=1 for one cycle, up_rsp_err<=0, last_grant<=grant, go to IDLE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no response: up_rsp_valid[grant] pulses with up_rsp_err=1 and up_port2=0, last_grant<=grant, go to IDLE.
  - If dn_rsp_valid and expiry coincide, the response wins (err=0).
- Latency:
  - Accept in cycle t gives dn_valid in cycle t+1.
  - dn_rsp_valid in cycle r gives up_rsp_valid in cycle r+1, coinciding with the return to IDLE.
  - Next acceptance is possible in cycle r+1.
  - Back-to-back minimum is 3 cycles per transaction.
- up_valid must stay asserted until ready. De-asserting it without ready just drops out of arbitration, with no error.
- Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.
- Reset asserted mid-transaction: in-flight request is abandoned, no response pulse, and a late dn_rsp_valid after reset is ignored in IDLE.
- up_rsp_valid and up_ready are never both asserted for the same requester in one cycle.

Decomposition:
- Package hs_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT_RSP}
  - default WIDTH constant 32
  - function next_rr index helper
- Sub-module rr_pick: combinational, inputs req[NREQ] and last[$clog2(NREQ)], outputs one-hot gnt and index. Reused by other shared-channel controllers.

Test Plan:
- Single requester: up_valid[0]=1, up_port1[0]=32'hA5A5_0001, dn_ready=1 immediately, response 32'h0000_1234 two cycles later -> up_ready[0] in cycle 0, dn_valid cycle 1, up_rsp_valid=2'b01 with up_port2=32'h1234, err=0.
- Both requesters continuously valid for 4 transactions -> grant order 0,1,0,1; each dn_port1 matches the granted requester's word.
- dn_ready held low 5 cycles in ISSUE -> dn_valid stays 1, dn_port1 unchanged, up_ready stays 0, busy=1.
- TIMEOUT=4, no response -> exactly 4 cycles in WAIT_RSP, then up_rsp_valid[grant]=1, up_rsp_err=1, up_port2=0, state IDLE; a later dn_rsp_valid produces no pulse.
- rst pulsed during WAIT_RSP -> all outputs 0 asynchronously; no response pulse after release; requester 0 is granted first after reset.
- Response and timeout in the same cycle (TIMEOUT=3, dn_rsp_valid on the 3rd WAIT_RSP cycle) -> up_rsp_err=0, up_port2 equals dn_port2.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared definitions for the handshake round-robin arbiter and related
// shared-channel controllers: FSM state type, default data width and the
// round-robin index helper.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } arb_state_t;

  localparam int unsigned HS_ARB_WIDTH = 32;

  // Index following idx in a ring of n entries.
  function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector, one bit per requester
//   last_i : index of the most recently served requester
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : index of the granted requester (zero when no request)
// The scan starts at last_i+1 and wraps, so last_i has lowest priority.
module rr_pick
  import hs_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = IW'(next_rr(32'(last_i), NREQ));
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
      cand = IW'(next_rr(32'(cand), NREQ));
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one downstream request/response channel
// between NREQ upstream requesters, one transaction outstanding at a time.
//   clk, rst            : clock, asynchronous active-high reset
//   up_valid/up_port1   : per-requester request valid and request words
//   up_ready            : combinational accept, one-hot or zero (IDLE only)
//   up_rsp_valid        : one-cycle response pulse to the granted requester
//   up_port2/up_rsp_err : broadcast response word / timeout flag (data 0)
//   dn_valid/dn_ready   : downstream request handshake, dn_port1 registered
//   dn_rsp_valid/dn_port2 : downstream response
//   busy                : a transaction is in flight
// TIMEOUT bounds the cycles spent waiting for a response; 0 disables it.
module handshake_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = HS_ARB_WIDTH,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       up_valid,
  input  logic [NREQ*WIDTH-1:0] up_port1,
  output logic [NREQ-1:0]       up_ready,
  output logic [NREQ-1:0]       up_rsp_valid,
  output logic [WIDTH-1:0]      up_port2,
  output logic                  up_rsp_err,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [WIDTH-1:0]      dn_port1,
  input  logic                  dn_rsp_valid,
  input  logic [WIDTH-1:0]      dn_port2,
  output logic                  busy
);

  localparam int unsigned IW    = $clog2(NREQ);
  localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_t state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dn_valid_q, dn_valid_d;
  logic [WIDTH-1:0] dn_port1_q, dn_port1_d;
  logic [NREQ-1:0]  up_rsp_valid_q, up_rsp_valid_d;
  logic [WIDTH-1:0] up_port2_q, up_port2_d;
  logic             up_rsp_err_q, up_rsp_err_d;

  logic [NREQ-1:0]  req_elig;
  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_word;

  // A requester receiving its response pulse this cycle is held out of
  // arbitration so it never sees ready and rsp_valid together.
  assign req_elig = up_valid & ~up_rsp_valid_q;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i (req_elig),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_word = up_port1[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    up_ready = '0;
    if (state_q == IDLE) up_ready = pick_gnt;
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    dn_valid_d     = dn_valid_q;
    dn_port1_d     = dn_port1_q;
    up_rsp_valid_d = '0;
    up_port2_d     = '0;
    up_rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          grant_d    = pick_idx;
          dn_port1_d = pick_word;
          dn_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (dn_ready) begin
          dn_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // Response is checked first so it wins over a coincident expiry.
        if (dn_rsp_valid) begin
          up_rsp_valid_d[grant_q] = 1'b1;
          up_port2_d              = dn_port2;
          last_d                  = grant_q;
          state_d                 = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          up_rsp_valid_d[grant_q] = 1'b1;
          up_rsp_err_d            = 1'b1;
          last_d                  = grant_q;
          state_d                 = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_q         <= IW'(NREQ - 1);
      cnt_q          <= '0;
      dn_valid_q     <= 1'b0;
      dn_port1_q     <= '0;
      up_rsp_valid_q <= '0;
      up_port2_q     <= '0;
      up_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      dn_valid_q     <= dn_valid_d;
      dn_port1_q     <= dn_port1_d;
      up_rsp_valid_q <= up_rsp_valid_d;
      up_port2_q     <= up_port2_d;
      up_rsp_err_q   <= up_rsp_err_d;
    end
  end

  assign dn_valid     = dn_valid_q;
  assign dn_port1     = dn_port1_q;
  assign up_rsp_valid = up_rsp_valid_q;
  assign up_port2     = up_port2_q;
  assign up_rsp_err   = up_rsp_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
module tb_handshake_rr_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       up_valid;
  logic [NREQ*WIDTH-1:0] up_port1;
  logic [NREQ-1:0]       up_ready;
  logic [NREQ-1:0]       up_rsp_valid;
  logic [WIDTH-1:0]      up_port2;
  logic                  up_rsp_err;
  logic                  dn_valid;
  logic                  dn_ready;
  logic [WIDTH-1:0]      dn_port1;
  logic                  dn_rsp_valid;
  logic [WIDTH-1:0]      dn_port2;
  logic                  busy;

  handshake_rr_arbiter #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_port1    (up_port1),
    .up_ready    (up_ready),
    .up_rsp_valid(up_rsp_valid),
    .up_port2    (up_port2),
    .up_rsp_err  (up_rsp_err),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_port1    (dn_port1),
    .dn_rsp_valid(dn_rsp_valid),
    .dn_port2    (dn_port2),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] rsp;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    up_valid     = '0;
    dn_ready     = 1'b0;
    dn_rsp_valid = 1'b0;
    dn_port2     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction per vector, idle gap after each response pulse.
  task automatic run_table();
    logic [31:0] word;
    for (int i = 0; i < 8; i++) begin
      tick();
      up_valid = vecs[i].valid;
      up_port1 = {vecs[i].w1, vecs[i].w0};
      #1;
      chk("tbl_ready", 64'(up_ready), 64'(vecs[i].exp_gnt));
      if (vecs[i].exp_gnt == 2'b00) begin
        tick();
        up_valid = '0;
        chk("tbl_idle_busy", 64'(busy), 64'(0));
        continue;
      end
      word = vecs[i].exp_gnt[1] ? vecs[i].w1 : vecs[i].w0;
      tick();
      up_valid = '0;
      chk("tbl_dn_valid", 64'(dn_valid), 64'(1));
      chk("tbl_dn_port1", 64'(dn_port1), 64'(word));
      dn_ready = 1'b1;
      tick();
      dn_ready = 1'b0;
      chk("tbl_dn_valid_drop", 64'(dn_valid), 64'(0));
      chk("tbl_busy_wait", 64'(busy), 64'(1));
      dn_rsp_valid = 1'b1;
      dn_port2     = vecs[i].rsp;
      tick();
      dn_rsp_valid = 1'b0;
      chk("tbl_rsp_valid", 64'(up_rsp_valid), 64'(vecs[i].exp_gnt));
      chk("tbl_port2", 64'(up_port2), 64'(vecs[i].rsp));
      chk("tbl_err", 64'(up_rsp_err), 64'(0));
      chk("tbl_busy_done", 64'(busy), 64'(0));
    end
  endtask

  // Both requesters held valid: 3-cycle back-to-back, alternating grants.
  task automatic seq_back_to_back();
    logic [1:0]  g;
    logic [1:0]  prev;
    logic [31:0] w0, w1;
    w0   = 32'h1111_0000;
    w1   = 32'h2222_0001;
    prev = 2'b00;
    tick();
    up_valid = 2'b11;
    up_port1 = {w1, w0};
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("b2b_ready", 64'(up_ready), 64'(g));
      chk("b2b_rsp_prev", 64'(up_rsp_valid), 64'(prev));
      chk("b2b_no_overlap", 64'(up_ready & up_rsp_valid), 64'(0));
      tick();
      chk("b2b_dn_valid", 64'(dn_valid), 64'(1));
      chk("b2b_dn_port1", 64'(dn_port1), 64'(g[1] ? w1 : w0));
      dn_ready = 1'b1;
      tick();
      dn_ready     = 1'b0;
      dn_rsp_valid = 1'b1;
      dn_port2     = 32'hB000_0000 + 32'(t);
      tick();
      dn_rsp_valid = 1'b0;
      prev = g;
      if (t == 3) up_valid = '0;
    end
    chk("b2b_last_rsp", 64'(up_rsp_valid), 64'(2'b10));
    chk("b2b_last_port2", 64'(up_port2), 64'(32'hB000_0003));
  endtask

  task automatic seq_stall();
    tick();
    up_valid = 2'b01;
    up_port1 = {32'h7777_0002, 32'h5555_0001};
    #1;
    chk("stall_ready", 64'(up_ready), 64'(2'b01));
    tick();
    up_valid = 2'b11;
    dn_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_dn_valid", 64'(dn_valid), 64'(1));
      chk("stall_dn_port1", 64'(dn_port1), 64'(32'h5555_0001));
      chk("stall_ready_low", 64'(up_ready), 64'(0));
      chk("stall_busy", 64'(busy), 64'(1));
      tick();
    end
    up_valid = '0;
    dn_ready = 1'b1;
    tick();
    dn_ready     = 1'b0;
    dn_rsp_valid = 1'b1;
    dn_port2     = 32'h0000_0042;
    tick();
    dn_rsp_valid = 1'b0;
    chk("stall_rsp", 64'(up_rsp_valid), 64'(2'b01));
  endtask

  task automatic seq_timeout();
    tick();
    up_valid = 2'b10;
    up_port1 = {32'h9999_0003, 32'h0};
    #1;
    chk("to_ready", 64'(up_ready), 64'(2'b10));
    tick();
    up_valid = '0;
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      chk("to_wait_busy", 64'(busy), 64'(1));
      chk("to_wait_norsp", 64'(up_rsp_valid), 64'(0));
      tick();
    end
    chk("to_rsp", 64'(up_rsp_valid), 64'(2'b10));
    chk("to_err", 64'(up_rsp_err), 64'(1));
    chk("to_port2", 64'(up_port2), 64'(0));
    chk("to_busy", 64'(busy), 64'(0));
    dn_rsp_valid = 1'b1;
    dn_port2     = 32'hDEAD_BEEF;
    tick();
    dn_rsp_valid = 1'b0;
    chk("to_late_rsp", 64'(up_rsp_valid), 64'(0));
  endtask

  // Response arrives on the same WAIT_RSP cycle the timeout would fire.
  task automatic seq_coincide();
    tick();
    up_valid = 2'b01;
    up_port1 = {32'h0, 32'h3333_0004};
    #1;
    chk("co_ready", 64'(up_ready), 64'(2'b01));
    tick();
    up_valid = '0;
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    for (int k = 1; k < int'(TIMEOUT); k++) tick();
    dn_rsp_valid = 1'b1;
    dn_port2     = 32'h00C0_FFEE;
    tick();
    dn_rsp_valid = 1'b0;
    chk("co_rsp", 64'(up_rsp_valid), 64'(2'b01));
    chk("co_err", 64'(up_rsp_err), 64'(0));
    chk("co_port2", 64'(up_port2), 64'(32'h00C0_FFEE));
  endtask

  task automatic seq_reset_mid();
    tick();
    up_valid = 2'b10;
    up_port1 = {32'h4444_0005, 32'h0};
    tick();
    up_valid = '0;
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_dn_valid", 64'(dn_valid), 64'(0));
    chk("rst_dn_port1", 64'(dn_port1), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp", 64'(up_rsp_valid), 64'(0));
    chk("rst_err", 64'(up_rsp_err), 64'(0));
    chk("rst_ready", 64'(up_ready), 64'(0));
    tick();
    tick();
    rst          = 1'b0;
    dn_rsp_valid = 1'b1;
    dn_port2     = 32'h1234_5678;
    tick();
    dn_rsp_valid = 1'b0;
    chk("rst_no_pulse", 64'(up_rsp_valid), 64'(0));
    chk("rst_idle", 64'(busy), 64'(0));
    up_valid = 2'b11;
    #1;
    chk("rst_first_gnt", 64'(up_ready), 64'(2'b01));
    up_valid = '0;
  endtask

  // Random traffic against a transaction-level model of the arbiter.
  task automatic run_random(input int cycles);
    int          phase;     // 0 idle, 1 request offered, 2 awaiting response
    int          g;
    int          last;
    int          waited;
    int          w;
    logic [1:0]  e_rsp;
    logic        e_err;
    logic [31:0] e_p2;
    logic        e_dnv;
    logic [31:0] e_dnp1;
    logic [1:0]  clr;
    logic [1:0]  cand;
    logic [1:0]  e_ready;
    phase = 0; g = 0; last = NREQ - 1; waited = 0;
    e_rsp = '0; e_err = 1'b0; e_p2 = '0; e_dnv = 1'b0; e_dnp1 = '0; clr = '0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("rnd_rsp_valid", 64'(up_rsp_valid), 64'(e_rsp));
      if (e_rsp != 0) begin
        chk("rnd_err", 64'(up_rsp_err), 64'(e_err));
        chk("rnd_port2", 64'(up_port2), 64'(e_p2));
      end
      chk("rnd_dn_valid", 64'(dn_valid), 64'(e_dnv));
      if (e_dnv) chk("rnd_dn_port1", 64'(dn_port1), 64'(e_dnp1));
      chk("rnd_busy", 64'(busy), 64'(phase != 0));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (clr[i]) begin
          up_valid[i] = 1'b0;
          clr[i]      = 1'b0;
        end else if (up_valid[i] && ($urandom % 16 == 0)) begin
          up_valid[i] = 1'b0;
        end else if (!up_valid[i] && ($urandom % 3 == 0)) begin
          up_valid[i]              = 1'b1;
          up_port1[i*WIDTH +: WIDTH] = $urandom;
        end
      end
      dn_ready     = 1'($urandom % 2);
      dn_rsp_valid = ($urandom % 3 == 0);
      dn_port2     = $urandom;
      #1;
      e_ready = '0;
      w = -1;
      if (phase == 0) begin
        cand = up_valid & ~e_rsp;
        for (int k = 1; k <= int'(NREQ); k++) begin
          if (w < 0 && cand[(last + k) % NREQ]) w = (last + k) % NREQ;
        end
        if (w >= 0) e_ready[w] = 1'b1;
      end
      chk("rnd_up_ready", 64'(up_ready), 64'(e_ready));
      e_rsp = '0;
      case (phase)
        0: if (w >= 0) begin
          g      = w;
          clr[w] = 1'b1;
          e_dnv  = 1'b1;
          e_dnp1 = up_port1[w*WIDTH +: WIDTH];
          phase  = 1;
        end
        1: if (dn_ready) begin
          e_dnv  = 1'b0;
          waited = 0;
          phase  = 2;
        end
        default: begin
          waited++;
          if (dn_rsp_valid) begin
            e_rsp[g] = 1'b1; e_err = 1'b0; e_p2 = dn_port2; last = g; phase = 0;
          end else if (waited == int'(TIMEOUT)) begin
            e_rsp[g] = 1'b1; e_err = 1'b1; e_p2 = '0; last = g; phase = 0;
          end
        end
      endcase
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 32'hA5A5_0001, 32'h0000_0000, 32'h0000_1234, 2'b01};
    vecs[1] = '{2'b11, 32'h1000_0001, 32'h2000_0001, 32'h0000_0011, 2'b10};
    vecs[2] = '{2'b11, 32'h1000_0002, 32'h2000_0002, 32'h0000_0022, 2'b01};
    vecs[3] = '{2'b10, 32'h1000_0003, 32'h2000_0003, 32'h0000_0033, 2'b10};
    vecs[4] = '{2'b10, 32'h1000_0004, 32'h2000_0004, 32'h0000_0044, 2'b10};
    vecs[5] = '{2'b01, 32'h1000_0005, 32'h2000_0005, 32'h0000_0055, 2'b01};
    vecs[6] = '{2'b00, 32'h1000_0006, 32'h2000_0006, 32'h0000_0066, 2'b00};
    vecs[7] = '{2'b11, 32'h1000_0007, 32'h2000_0007, 32'h0000_0077, 2'b10};

    rst      = 1'b1;
    up_port1 = '0;
    idle_inputs();
    #1;
    chk("reset_dn_valid", 64'(dn_valid), 64'(0));
    chk("reset_dn_port1", 64'(dn_port1), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_rsp", 64'(up_rsp_valid), 64'(0));
    chk("reset_err", 64'(up_rsp_err), 64'(0));
    chk("reset_port2", 64'(up_port2), 64'(0));
    chk("reset_ready", 64'(up_ready), 64'(0));
    tick();
    rst = 1'b0;

    run_table();
    seq_back_to_back();
    seq_stall();
    seq_timeout();
    seq_coincide();
    seq_reset_mid();
    do_reset();
    run_random(400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
